// File: rtl/serdes_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serdes_rx_frame_ctrl
//  Purpose  : Receive-side framing controller for the serial link feeding the
//             8-bit deserializer. Hunts the bitstream for SYNC_WORD, verifies
//             that it recurs at the frame period, then emits aligned 8-bit
//             data words and polices the periodic sync slots.
//  Ports    : clk        - system clock, one serial bit per rising edge
//             rst        - synchronous active-high reset
//             en         - enable; low behaves as reset but keeps err_count
//             serial_in  - serial data bit, MSB first
//             word_out   - aligned data word (holds when word_valid is low)
//             word_valid - one-cycle strobe qualifying word_out
//             locked     - high while in LOCKED
//             sync_err   - one-cycle pulse per bad sync slot while LOCKED
//             err_count  - saturating count of sync_err pulses
//             state      - 0 = HUNT, 1 = VERIFY, 2 = LOCKED
//  Revision : 1.0 - initial release
// ============================================================================
module serdes_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         FRAME_LEN = 4,
    parameter int         LOCK_CNT  = 2,
    parameter int         MISS_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        serial_in,
    output logic [7:0]  word_out,
    output logic        word_valid,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam int WC_W   = $clog2(FRAME_LEN + 1);
    localparam int HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [WC_W-1:0]   FRAME_LEN_C = WC_W'(FRAME_LEN);
    localparam logic [HIT_W-1:0]  LOCK_CNT_C  = HIT_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_MAX_C  = MISS_W'(MISS_MAX);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    // Only the 7 most recent bits need storing; the 8th comes from serial_in.
    logic [6:0]         sr_q,         sr_d;
    logic [2:0]         bit_cnt_q,    bit_cnt_d;
    logic [WC_W-1:0]    word_cnt_q,   word_cnt_d;
    logic [HIT_W-1:0]   hits_q,       hits_d;
    logic [MISS_W-1:0]  miss_cnt_q,   miss_cnt_d;
    logic [7:0]         word_out_q,   word_out_d;
    logic               word_valid_q, word_valid_d;
    logic               sync_err_q,   sync_err_d;
    logic [15:0]        err_count_q,  err_count_d;

    logic [7:0]         sr_next;
    logic               word_done;
    logic               sync_slot;
    logic               sync_ok;

    assign sr_next   = {sr_q, serial_in};
    assign word_done = (bit_cnt_q == 3'd7);
    assign sync_slot = (word_cnt_q == FRAME_LEN_C);
    assign sync_ok   = (sr_next == SYNC_WORD);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_next[6:0];
        bit_cnt_d    = bit_cnt_q + 3'd1;
        word_cnt_d   = word_cnt_q;
        hits_d       = hits_q;
        miss_cnt_d   = miss_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        err_count_d  = err_count_q;

        case (state_q)
            ST_HUNT: begin
                // Bit-granular search: the hit itself defines the word grid.
                if (sync_ok) begin
                    state_d    = ST_VERIFY;
                    bit_cnt_d  = 3'd0;
                    word_cnt_d = '0;
                    hits_d     = HIT_W'(1);
                end
            end

            ST_VERIFY: begin
                if (word_done) begin
                    if (!sync_slot) begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end else begin
                        word_cnt_d = '0;
                        if (sync_ok) begin
                            hits_d = hits_q + HIT_W'(1);
                            if (hits_q + HIT_W'(1) == LOCK_CNT_C) begin
                                state_d    = ST_LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
            end

            ST_LOCKED: begin
                if (word_done) begin
                    if (!sync_slot) begin
                        word_cnt_d   = word_cnt_q + WC_W'(1);
                        word_out_d   = sr_next;
                        word_valid_d = 1'b1;
                    end else begin
                        word_cnt_d = '0;
                        if (sync_ok) begin
                            miss_cnt_d = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                            // Alignment is kept until the miss limit is hit.
                            if (miss_cnt_q + MISS_W'(1) == MISS_MAX_C) begin
                                state_d = ST_HUNT;
                            end else begin
                                miss_cnt_d = miss_cnt_q + MISS_W'(1);
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            hits_q       <= '0;
            miss_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else if (!en) begin
            // Disabled looks like reset, but the error history survives.
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            hits_q       <= '0;
            miss_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            hits_q       <= hits_d;
            miss_cnt_q   <= miss_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            sync_err_q   <= sync_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign sync_err   = sync_err_q;
    assign err_count  = err_count_q;
    assign state      = state_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_serdes_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serdes_rx_frame_ctrl
//  Purpose  : Self-checking bench for serdes_rx_frame_ctrl. A frame-position
//             reference model predicts emitted words and sync errors into a
//             scoreboard queue; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serdes_rx_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int FL = 4;
    localparam int LC = 2;
    localparam int MM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        serial_in = 1'b0;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        locked;
    logic        sync_err;
    logic [15:0] err_count;
    logic [1:0]  state;

    serdes_rx_frame_ctrl #(
        .SYNC_WORD (SYNC),
        .FRAME_LEN (FL),
        .LOCK_CNT  (LC),
        .MISS_MAX  (MM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .serial_in  (serial_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_count  (err_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;

    // Reference model: mode 0/1/2 = hunt/verify/locked; m_pos counts bits
    // since the last sync boundary, so byte index = m_pos/8.
    int         m_mode = 0;
    logic [7:0] m_hist = 8'h00;
    int         m_pos  = 0;
    int         m_good = 0;
    int         m_miss = 0;
    int         m_errs = 0;
    logic [7:0] m_last = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic pop_check(input bit is_err, input logic [7:0] v);
        exp_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %s 0x%0h at cycle %0d, expected nothing",
                     is_err ? "sync_err" : "word", v, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.is_err != is_err || e.cyc != cyc || (!is_err && e.val != v)) begin
                n_fail++;
                $display("FAIL sb_compare: got %s 0x%0h at cycle %0d, expected %s 0x%0h at cycle %0d",
                         is_err ? "sync_err" : "word", v, cyc,
                         e.is_err ? "sync_err" : "word", e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (word_valid === 1'b1) begin
            n_words++;
            pop_check(1'b0, word_out);
        end
        if (sync_err === 1'b1) begin
            pop_check(1'b1, 8'h00);
        end
    end

    // Drive one bit (with current rst/en), advance the model, clock once and
    // check the per-cycle status outputs.
    task automatic step(input logic b);
        exp_t e;
        serial_in = b;
        if (rst) begin
            m_mode = 0; m_hist = 8'h00; m_errs = 0; m_last = 8'h00;
        end else if (!en) begin
            m_mode = 0; m_hist = 8'h00; m_last = 8'h00;
        end else begin
            m_hist = {m_hist[6:0], b};
            if (m_mode == 0) begin
                if (m_hist == SYNC) begin
                    m_mode = 1; m_pos = 0; m_good = 1;
                end
            end else begin
                m_pos++;
                if (m_pos % 8 == 0) begin
                    if (m_pos / 8 <= FL) begin
                        if (m_mode == 2) begin
                            m_last = m_hist;
                            e.is_err = 1'b0; e.val = m_hist; e.cyc = cyc + 1;
                            sbq.push_back(e);
                        end
                    end else begin
                        m_pos = 0;
                        if (m_mode == 1) begin
                            if (m_hist == SYNC) begin
                                m_good++;
                                if (m_good == LC) begin
                                    m_mode = 2; m_miss = 0;
                                end
                            end else begin
                                m_mode = 0;
                            end
                        end else begin
                            if (m_hist == SYNC) begin
                                m_miss = 0;
                            end else begin
                                if (m_errs < 65535) m_errs++;
                                e.is_err = 1'b1; e.val = 8'h00; e.cyc = cyc + 1;
                                sbq.push_back(e);
                                m_miss++;
                                if (m_miss == MM) m_mode = 0;
                            end
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("state", int'(state), m_mode);
        check("locked", int'(locked), (m_mode == 2) ? 1 : 0);
        check("err_count", int'(err_count), m_errs);
        check("word_out_hold", int'(word_out), int'(m_last));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic send_data4(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    int words_before;

    initial begin
        @(posedge clk);
        #1;
        // 1. Reset with random serial input
        rst = 1'b1; en = 1'b1;
        step(1'($urandom)); step(1'($urandom));
        check("t1_state", int'(state), 0);
        check("t1_locked", int'(locked), 0);
        check("t1_word_valid", int'(word_valid), 0);
        check("t1_err_count", int'(err_count), 0);
        rst = 1'b0;

        // 2. Acquisition
        step(1'b0); step(1'b1); step(1'b1);
        send_byte(8'hA5);
        check("t2_verify", int'(state), 1);
        send_data4(8'h11, 8'h22, 8'h33, 8'h44);
        send_byte(8'hA5);
        check("t2_locked", int'(locked), 1);
        send_data4(8'h55, 8'h66, 8'h77, 8'h88);
        send_byte(8'hA5);
        send_data4(8'h01, 8'h02, 8'h03, 8'h04);
        send_byte(8'hA5);
        check("t2_word_count", n_words, 8);

        // 3. Single bad sync slot
        send_data4(8'h10, 8'h20, 8'h30, 8'h40);
        send_byte(8'h5A);
        check("t3_sync_err", int'(sync_err), 1);
        check("t3_err_count", int'(err_count), 1);
        check("t3_locked", int'(locked), 1);
        send_data4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        send_byte(8'hA5);

        // 4. Loss of lock after three consecutive misses (err_count is
        // cumulative with the miss from step 3)
        for (int k = 0; k < 3; k++) begin
            send_data4(8'h31, 8'h32, 8'h33, 8'h34);
            send_byte(8'h5A);
            check("t4_sync_err", int'(sync_err), 1);
        end
        check("t4_locked", int'(locked), 0);
        check("t4_state", int'(state), 0);
        check("t4_err_count", int'(err_count), 4);

        // 5. False sync
        words_before = n_words;
        send_byte(8'hA5);
        check("t5_verify", int'(state), 1);
        send_data4(8'h12, 8'h34, 8'h56, 8'h78);
        send_byte(8'h00);
        check("t5_state", int'(state), 0);
        check("t5_no_words", n_words - words_before, 0);

        // 6. Enable drop and reset mid-frame
        send_byte(8'hA5);
        send_data4(8'h11, 8'h22, 8'h33, 8'h44);
        send_byte(8'hA5);
        check("t6_locked", int'(locked), 1);
        send_byte(8'h9E);
        step(1'b1); step(1'b0); step(1'b1);
        en = 1'b0;
        step(1'b1);
        en = 1'b1;
        check("t6_en_state", int'(state), 0);
        check("t6_en_locked", int'(locked), 0);
        check("t6_en_err_count", int'(err_count), 4);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        check("t6_rst_err_count", int'(err_count), 0);
        send_byte(8'hA5);
        send_data4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        check("t6_relock_verify", int'(state), 1);
        send_byte(8'hA5);
        check("t6_relock_locked", int'(locked), 1);

        // Randomized frames with corrupted syncs, slips, enable drops, resets
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                int n = $urandom_range(1, 11);
                for (int i = 0; i < n; i++) step(1'($urandom));
            end
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom));
            else send_byte(SYNC);
            for (int w = 0; w < FL; w++) begin
                if ($urandom_range(0, 40) == 0) begin
                    en = 1'b0;
                    step(1'($urandom));
                    en = 1'b1;
                end
                if ($urandom_range(0, 80) == 0) begin
                    rst = 1'b1;
                    step(1'($urandom));
                    rst = 1'b0;
                end
                send_byte(8'($urandom));
            end
        end

        @(negedge clk);
        #1;
        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
